// File: rtl/cache_ctrl_if.sv
// CPU-side and SDRAM-side signal bundle of the cache controller.
// The slave modport is the controller; master is the CPU/memory environment.
interface cache_ctrl_if;
  logic [15:0] Address;
  logic        wr_rd;
  logic        cs;
  logic [7:0]  DOut;
  logic [7:0]  DIn;
  logic        rdy;
  logic        ovf;
  logic [15:0] mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic        mem_strb;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport slave (
    input  Address, wr_rd, cs, DOut, mem_rdata, mem_ack,
    output DIn, rdy, ovf, mem_addr, mem_wr, mem_wdata, mem_strb
  );

  modport master (
    output Address, wr_rd, cs, DOut, mem_rdata, mem_ack,
    input  DIn, rdy, ovf, mem_addr, mem_wr, mem_wdata, mem_strb
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache, 8 lines x 32 bytes, in front of a
// byte-wide strobe/ack SDRAM port. One-deep pending slot catches requests made while busy.
module cache_ctrl (
  input  logic        clk,
  input  logic        rst,
  cache_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    ACCESS = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic        cs_q_r, edge_s, ack_s, hit_s;
  logic [15:0] req_addr_r, pend_addr_r;
  logic [7:0]  req_data_r, pend_data_r;
  logic        req_wr_r, pend_wr_r, pend_vld_r, ovf_r;
  logic [7:0]  tag_r [0:7];
  logic [7:0]  valid_r, dirty_r;
  logic [7:0]  data_r [0:255];
  logic [2:0]  idx_s;
  logic [7:0]  rtag_s;
  logic [4:0]  off_s;
  logic        rdy_r, mem_strb_r, mem_wr_r;
  logic [15:0] mem_addr_r;
  logic [7:0]  mem_wdata_r, din_r;

  assign edge_s = bus.cs & ~cs_q_r;
  assign idx_s  = req_addr_r[7:5];
  assign rtag_s = req_addr_r[15:8];
  assign off_s  = req_addr_r[4:0];
  assign hit_s  = valid_r[idx_s] & (tag_r[idx_s] == rtag_s);
  // Acks are only meaningful while a byte request is outstanding.
  assign ack_s  = bus.mem_ack & mem_strb_r;

  // State and byte counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; the byte counter advances only on an accepted ack.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (edge_s || pend_vld_r) state_s = LOOKUP;
        else                      state_s = IDLE;
      end
      LOOKUP: begin
        cnt_s = 5'd0;
        if (hit_s)                 state_s = ACCESS;
        else if (dirty_r[idx_s])   state_s = WB;
        else                       state_s = FILL;
      end
      WB: begin
        if (ack_s) begin
          cnt_s = cnt_r + 5'd1;
          if (cnt_r == 5'd31) state_s = FILL;
          else                state_s = WB;
        end else begin
          state_s = WB;
        end
      end
      FILL: begin
        if (ack_s) begin
          cnt_s = cnt_r + 5'd1;
          if (cnt_r == 5'd31) state_s = ACCESS;
          else                state_s = FILL;
        end else begin
          state_s = FILL;
        end
      end
      ACCESS:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request capture: the pending slot is older than a fresh edge and wins in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q_r      <= 1'b0;
      req_addr_r  <= 16'd0;
      req_wr_r    <= 1'b0;
      req_data_r  <= 8'd0;
      pend_vld_r  <= 1'b0;
      pend_addr_r <= 16'd0;
      pend_wr_r   <= 1'b0;
      pend_data_r <= 8'd0;
      ovf_r       <= 1'b0;
    end else begin
      cs_q_r <= bus.cs;
      if (state_r == IDLE) begin
        if (pend_vld_r) begin
          req_addr_r <= pend_addr_r;
          req_wr_r   <= pend_wr_r;
          req_data_r <= pend_data_r;
          pend_vld_r <= edge_s;
          if (edge_s) begin
            pend_addr_r <= bus.Address;
            pend_wr_r   <= bus.wr_rd;
            pend_data_r <= bus.DOut;
          end
        end else if (edge_s) begin
          req_addr_r <= bus.Address;
          req_wr_r   <= bus.wr_rd;
          req_data_r <= bus.DOut;
        end
      end else if (edge_s) begin
        if (!pend_vld_r) begin
          pend_vld_r  <= 1'b1;
          pend_addr_r <= bus.Address;
          pend_wr_r   <= bus.wr_rd;
          pend_data_r <= bus.DOut;
        end else begin
          ovf_r <= 1'b1;
        end
      end
    end
  end

  // Line metadata; reset invalidates everything so a half-filled line never hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) tag_r[i] <= 8'd0;
      valid_r <= 8'd0;
      dirty_r <= 8'd0;
    end else if (state_r == FILL && ack_s && cnt_r == 5'd31) begin
      tag_r[idx_s]   <= rtag_s;
      valid_r[idx_s] <= 1'b1;
      dirty_r[idx_s] <= 1'b0;
    end else if (state_r == ACCESS && req_wr_r) begin
      dirty_r[idx_s] <= 1'b1;
    end
  end

  // Data array, deliberately without reset.
  always_ff @(posedge clk) begin
    if (state_r == FILL && ack_s) begin
      data_r[{idx_s, cnt_r}] <= bus.mem_rdata;
    end else if (state_r == ACCESS && req_wr_r) begin
      data_r[{idx_s, off_s}] <= req_data_r;
    end
  end

  // Registered outputs, computed from the upcoming state and byte count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_r       <= 1'b1;
      mem_strb_r  <= 1'b0;
      mem_wr_r    <= 1'b0;
      mem_addr_r  <= 16'd0;
      mem_wdata_r <= 8'd0;
      din_r       <= 8'd0;
    end else begin
      rdy_r      <= (state_s == IDLE);
      mem_strb_r <= (state_s == WB) || (state_s == FILL);
      mem_wr_r   <= (state_s == WB);
      if (state_s == WB) begin
        mem_addr_r  <= {tag_r[idx_s], idx_s, cnt_s};
        mem_wdata_r <= data_r[{idx_s, cnt_s}];
      end else if (state_s == FILL) begin
        mem_addr_r <= {rtag_s, idx_s, cnt_s};
      end
      if (state_r == ACCESS && !req_wr_r) din_r <= data_r[{idx_s, off_s}];
    end
  end

  assign bus.DIn       = din_r;
  assign bus.rdy       = rdy_r;
  assign bus.ovf       = ovf_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wr    = mem_wr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_strb  = mem_strb_r;
endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: flat-memory reference model plus a per-line
// presence model predicting hit/miss latency and SDRAM traffic.
module tb_cache_ctrl;
  logic clk = 1'b0;
  logic rst;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          max_delay = 0;
  bit          stray_en  = 1'b0;
  logic [7:0]  sdram   [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] log_addr [$];
  logic        log_wr   [$];
  logic [7:0]  log_data [$];
  logic [7:0]  m_tag [0:7];
  logic [7:0]  m_valid, m_dirty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 1 on hit; on miss the line becomes present and clean.
  function automatic bit touch_line(input logic [15:0] a);
    logic [2:0] i;
    i = a[7:5];
    if (m_valid[i] && m_tag[i] == a[15:8]) return 1'b1;
    m_valid[i] = 1'b1;
    m_tag[i]   = a[15:8];
    m_dirty[i] = 1'b0;
    return 1'b0;
  endfunction

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (bus.rdy !== 1'b1 && lat < 2000) begin
      lat++;
      @(negedge clk);
    end
    check("rdy_timeout", 32'(lat < 2000), 32'd1);
  endtask

  task automatic do_op(input logic wr, input logic [15:0] a, input logic [7:0] d, input bit chk_lat);
    logic [2:0]  i;
    logic [7:0]  old_tag, din_before;
    logic [15:0] x;
    bit          was_dirty, hit;
    int          exp_lat, lat, n;
    logic [15:0] ea [$];
    logic        ew [$];
    logic [7:0]  ed [$];
    i = a[7:5];
    old_tag   = m_tag[i];
    was_dirty = m_valid[i] & m_dirty[i];
    hit       = touch_line(a);
    if (!hit && was_dirty) begin
      for (int k = 0; k < 32; k++) begin
        x = {old_tag, i, k[4:0]};
        ea.push_back(x); ew.push_back(1'b1); ed.push_back(ref_mem[x]);
      end
    end
    if (!hit) begin
      for (int k = 0; k < 32; k++) begin
        x = {a[15:8], i, k[4:0]};
        ea.push_back(x); ew.push_back(1'b0); ed.push_back(8'd0);
      end
    end
    exp_lat = hit ? 2 : (was_dirty ? 66 : 34);
    log_addr.delete(); log_wr.delete(); log_data.delete();
    din_before = bus.DIn;
    @(negedge clk);
    bus.Address = a; bus.wr_rd = wr; bus.DOut = d; bus.cs = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0;
    wait_rdy(lat);
    if (chk_lat) check($sformatf("latency@%h", a), lat, exp_lat);
    check($sformatf("traffic_len@%h", a), log_addr.size(), ea.size());
    n = (log_addr.size() < ea.size()) ? log_addr.size() : ea.size();
    for (int k = 0; k < n; k++) begin
      check($sformatf("mem_addr[%0d]@%h", k, a), log_addr[k], ea[k]);
      check($sformatf("mem_wr[%0d]@%h", k, a), log_wr[k], ew[k]);
      if (ew[k]) check($sformatf("wb_data[%0d]@%h", k, a), log_data[k], ed[k]);
    end
    if (wr) begin
      ref_mem[a] = d;
      m_dirty[i] = 1'b1;
      check($sformatf("din_hold@%h", a), bus.DIn, din_before);
    end else begin
      check($sformatf("din@%h", a), bus.DIn, ref_mem[a]);
    end
  endtask

  // SDRAM responder: random 0..max_delay wait per byte, optional stray acks when idle.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 8'd0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (bus.mem_strb === 1'b1) begin
        if (wait_cnt == 0) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_wr) sdram[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = sdram[bus.mem_addr];
          log_addr.push_back(bus.mem_addr);
          log_wr.push_back(bus.mem_wr);
          log_data.push_back(bus.mem_wr ? bus.mem_wdata : bus.mem_rdata);
          wait_cnt = $urandom_range(0, max_delay);
        end else begin
          wait_cnt--;
        end
      end else begin
        wait_cnt = $urandom_range(0, max_delay);
        if (stray_en && $urandom_range(0, 2) == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = 8'($urandom);
        end
      end
    end
  end

  initial begin
    int          lat;
    logic [15:0] a;
    logic [7:0]  exp_a, exp_b;
    for (int k = 0; k < 65536; k++) begin
      sdram[k]   = 8'($urandom);
      ref_mem[k] = sdram[k];
    end
    for (int k = 0; k < 8; k++) m_tag[k] = 8'd0;
    m_valid = 8'd0;
    m_dirty = 8'd0;
    rst = 1'b1;
    bus.cs = 1'b0; bus.Address = 16'd0; bus.wr_rd = 1'b0; bus.DOut = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rdy", bus.rdy, 32'd1);
    check("reset_din", bus.DIn, 32'd0);
    check("reset_strb", bus.mem_strb, 32'd0);
    check("reset_addr", bus.mem_addr, 32'd0);
    check("reset_wr", bus.mem_wr, 32'd0);
    check("reset_wdata", bus.mem_wdata, 32'd0);
    check("reset_ovf", bus.ovf, 32'd0);

    // Directed scenario: allocate, hit, clean conflict, dirty eviction.
    do_op(1'b1, 16'h1100, 8'hAA, 1'b1);
    do_op(1'b1, 16'h1101, 8'hBB, 1'b1);
    do_op(1'b0, 16'h1100, 8'h00, 1'b1);
    check("din_aa", bus.DIn, 32'h0000_00AA);
    do_op(1'b0, 16'h3346, 8'h00, 1'b1);
    do_op(1'b0, 16'h4444, 8'h00, 1'b1);
    do_op(1'b1, 16'h5504, 8'hCC, 1'b1);
    check("wb_byte0", sdram[16'h1100], 32'h0000_00AA);
    check("wb_byte1", sdram[16'h1101], 32'h0000_00BB);
    do_op(1'b0, 16'h5504, 8'h00, 1'b1);

    // Random traffic with slow memory and stray acks.
    max_delay = 3;
    stray_en  = 1'b1;
    for (int n = 0; n < 60; n++) begin
      a = {8'h10 + 8'($urandom_range(0, 3)), 8'($urandom)};
      do_op(1'($urandom_range(0, 1)), a, 8'($urandom), 1'b0);
    end
    max_delay = 0;
    stray_en  = 1'b0;
    repeat (2) @(negedge clk);

    // Three edges during one miss: second pends, third overflows.
    check("ovf_before", bus.ovf, 32'd0);
    exp_a = ref_mem[16'h7720];
    exp_b = ref_mem[16'h7725];
    void'(touch_line(16'h7720));
    void'(touch_line(16'h7725));
    @(negedge clk);
    bus.Address = 16'h7720; bus.wr_rd = 1'b0; bus.cs = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (3) @(negedge clk);
    bus.Address = 16'h7725; bus.cs = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0;
    repeat (2) @(negedge clk);
    bus.Address = 16'h9999; bus.wr_rd = 1'b1; bus.DOut = 8'h5A; bus.cs = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr_rd = 1'b0;
    @(negedge clk);
    check("ovf_set", bus.ovf, 32'd1);
    wait_rdy(lat);
    check("pend_first_din", bus.DIn, exp_a);
    @(negedge clk);
    check("pend_one_idle", bus.rdy, 32'd0);
    wait_rdy(lat);
    check("pend_second_din", bus.DIn, exp_b);
    check("ovf_sticky", bus.ovf, 32'd1);

    // Reset in the middle of a line fill.
    a = 16'h2260;
    @(negedge clk);
    bus.Address = a; bus.wr_rd = 1'b0; bus.cs = 1'b1;
    @(negedge clk);
    bus.cs = 1'b0;
    lat = 0;
    while (!(bus.mem_strb === 1'b1 && bus.mem_wr === 1'b0) && lat < 200) begin
      lat++;
      @(negedge clk);
    end
    check("fill_reached", 32'(lat < 200), 32'd1);
    repeat (5) @(negedge clk);
    check("strb_in_fill", bus.mem_strb, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_strb", bus.mem_strb, 32'd0);
    check("rst_rdy", bus.rdy, 32'd1);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_ovf", bus.ovf, 32'd0);
    check("rst_din", bus.DIn, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_valid = 8'd0;
    m_dirty = 8'd0;
    for (int k = 0; k < 65536; k++) ref_mem[k] = sdram[k];
    @(negedge clk);
    do_op(1'b0, a, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
